// File: rtl/vpg_word_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : vpg_word_gen
//  Brief    : Video pattern generator. Free-running H/V timing with a scaled
//             5x7 bitmap-font word overlay chosen by sel, latched per frame.
//             Three-stage pipeline: counters -> font ROM -> pixel mux.
//  Options  : VPG_WORD_BLINK_EN - blink the word every BLINK_FRAMES frames.
//  Revision : 1.0 - initial release
// ============================================================================
module vpg_word_gen #(
    parameter int          H_ACTIVE     = 640,
    parameter int          H_FP         = 16,
    parameter int          H_SYNC       = 96,
    parameter int          H_BP         = 48,
    parameter int          V_ACTIVE     = 480,
    parameter int          V_FP         = 10,
    parameter int          V_SYNC       = 2,
    parameter int          V_BP         = 33,
    parameter int          HS_POL       = 0,
    parameter int          VS_POL       = 0,
    parameter int          SCALE        = 12,
    parameter int          X0           = 140,
    parameter int          Y0           = 198,
    parameter logic [23:0] FG_RGB       = 24'h78FFFF,
    parameter logic [23:0] BG_RGB       = 24'hFFFFFF,
    parameter int          BLINK_FRAMES = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] sel,
    output logic       vpg_de,
    output logic       vpg_hs,
    output logic       vpg_vs,
    output logic [7:0] vpg_r,
    output logic [7:0] vpg_g,
    output logic [7:0] vpg_b,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);
    localparam int SW      = (SCALE > 1) ? $clog2(SCALE) : 1;

    // Text box edges clipped to the active area so it never reaches blanking
    localparam int HB_BEG  = (X0 < H_ACTIVE) ? X0 : H_ACTIVE;
    localparam int HB_END  = (X0 + 30 * SCALE < H_ACTIVE) ? X0 + 30 * SCALE : H_ACTIVE;
    localparam int VB_BEG  = (Y0 < V_ACTIVE) ? Y0 : V_ACTIVE;
    localparam int VB_END  = (Y0 + 7 * SCALE < V_ACTIVE) ? Y0 + 7 * SCALE : V_ACTIVE;

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] HS_BEG     = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] HBOX_BEG   = HW'(HB_BEG);
    localparam logic [HW-1:0] HBOX_END   = HW'(HB_END);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG     = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] VBOX_BEG   = VW'(VB_BEG);
    localparam logic [VW-1:0] VBOX_END   = VW'(VB_END);
    localparam logic [SW-1:0] S_LAST     = SW'(SCALE - 1);
    localparam logic          HS_ON      = (HS_POL != 0);
    localparam logic          VS_ON      = (VS_POL != 0);

    if (SCALE < 1 || SCALE > 15) begin : g_bad_scale
        $error("vpg_word_gen: SCALE must be 1..15");
    end
    if (BLINK_FRAMES < 1) begin : g_bad_blink
        $error("vpg_word_gen: BLINK_FRAMES must be >= 1");
    end

`ifdef VPG_WORD_BLINK_EN
    localparam int                BLINK_W    = $clog2(2 * BLINK_FRAMES + 1);
    localparam logic [BLINK_W-1:0] BLINK_HALF = BLINK_W'(BLINK_FRAMES);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(2 * BLINK_FRAMES - 1);
    logic [BLINK_W-1:0] blink_q, blink_d;
`endif

    // Stage 0 state
    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic [SW-1:0] sx_q, sx_d, sy_q, sy_d;
    logic [2:0]    col_q, col_d, chr_q, chr_d, row_q, row_d;
    logic [2:0]    word_q, word_d;
    logic          in_box_x, in_box_y, frame_first, show_text;
    logic [4:0]    glyph;
    logic [5:0]    row_bits;
    // Stage 1 state
    logic          s1_de_q, s1_de_d, s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d;
    logic          s1_fs_q, s1_fs_d, s1_txt_q, s1_txt_d;
    logic [2:0]    s1_col_q, s1_col_d;
    logic [5:0]    s1_bits_q, s1_bits_d;
    // Stage 2 state (outputs)
    logic          de_q, de_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
    logic [23:0]   rgb_q, rgb_d;

    // Letter index for each character cell of each word (0 = blank glyph)
    function automatic logic [3:0] char_code(input logic [2:0] word, input logic [2:0] idx);
        logic [19:0] s;
        case (word)
            3'd1:    s = {4'd1,  4'd2,  4'd3,  4'd3,  4'd4};  // H E L L O
            3'd2:    s = {4'd5,  4'd2,  4'd6,  4'd7,  4'd0};  // D E A F
            3'd3:    s = {4'd8,  4'd4,  4'd9,  4'd0,  4'd0};  // Y O U
            3'd4:    s = {4'd10, 4'd2,  4'd0,  4'd0,  4'd0};  // M E
            3'd5:    s = {4'd11, 4'd12, 4'd13, 4'd14, 4'd0};  // S I G N
            default: s = '0;
        endcase
        case (idx)
            3'd0:    char_code = s[19:16];
            3'd1:    char_code = s[15:12];
            3'd2:    char_code = s[11:8];
            3'd3:    char_code = s[7:4];
            3'd4:    char_code = s[3:0];
            default: char_code = 4'd0;
        endcase
    endfunction

    // 5x7 glyph rows, top row first, leftmost dot in the MSB of each row
    function automatic logic [4:0] glyph_row(input logic [3:0] code, input logic [2:0] row);
        logic [34:0] g;
        case (code)
            4'd1:    g = {5'b10001, 5'b10001, 5'b10001, 5'b11111, 5'b10001, 5'b10001, 5'b10001}; // H
            4'd2:    g = {5'b11111, 5'b10000, 5'b10000, 5'b11110, 5'b10000, 5'b10000, 5'b11111}; // E
            4'd3:    g = {5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b11111}; // L
            4'd4:    g = {5'b01110, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b01110}; // O
            4'd5:    g = {5'b11110, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b11110}; // D
            4'd6:    g = {5'b01110, 5'b10001, 5'b10001, 5'b11111, 5'b10001, 5'b10001, 5'b10001}; // A
            4'd7:    g = {5'b11111, 5'b10000, 5'b10000, 5'b11110, 5'b10000, 5'b10000, 5'b10000}; // F
            4'd8:    g = {5'b10001, 5'b10001, 5'b01010, 5'b00100, 5'b00100, 5'b00100, 5'b00100}; // Y
            4'd9:    g = {5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b01110}; // U
            4'd10:   g = {5'b10001, 5'b11011, 5'b10101, 5'b10101, 5'b10001, 5'b10001, 5'b10001}; // M
            4'd11:   g = {5'b01111, 5'b10000, 5'b10000, 5'b01110, 5'b00001, 5'b00001, 5'b11110}; // S
            4'd12:   g = {5'b01110, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b01110}; // I
            4'd13:   g = {5'b01110, 5'b10001, 5'b10000, 5'b10111, 5'b10001, 5'b10001, 5'b01111}; // G
            4'd14:   g = {5'b10001, 5'b11001, 5'b10101, 5'b10011, 5'b10001, 5'b10001, 5'b10001}; // N
            default: g = '0;
        endcase
        case (row)
            3'd0:    glyph_row = g[34:30];
            3'd1:    glyph_row = g[29:25];
            3'd2:    glyph_row = g[24:20];
            3'd3:    glyph_row = g[19:15];
            3'd4:    glyph_row = g[14:10];
            3'd5:    glyph_row = g[9:5];
            3'd6:    glyph_row = g[4:0];
            default: glyph_row = 5'd0;
        endcase
    endfunction

    // Free-running raster counters and text-box window flags
    always_comb begin
        h_cnt_d = h_cnt_q + HW'(1);
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
        end
        in_box_x    = (h_cnt_q >= HBOX_BEG) && (h_cnt_q < HBOX_END);
        in_box_y    = (v_cnt_q >= VBOX_BEG) && (v_cnt_q < VBOX_END);
        frame_first = (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    // Horizontal dot chain: sub-pixel -> dot column (0..5) -> character cell
    always_comb begin
        sx_d  = sx_q;
        col_d = col_q;
        chr_d = chr_q;
        if (h_cnt_d == HBOX_BEG) begin
            sx_d  = '0;
            col_d = '0;
            chr_d = '0;
        end else if (in_box_x) begin
            if (sx_q == S_LAST) begin
                sx_d = '0;
                if (col_q == 3'd5) begin
                    col_d = '0;
                    chr_d = chr_q + 3'd1;
                end else begin
                    col_d = col_q + 3'd1;
                end
            end else begin
                sx_d = sx_q + SW'(1);
            end
        end
    end

    // Vertical dot chain: steps once per box line, after its last active pixel
    always_comb begin
        sy_d  = sy_q;
        row_d = row_q;
        if ((h_cnt_d == '0) && (v_cnt_d == '0)) begin
            sy_d  = '0;
            row_d = '0;
        end else if ((h_cnt_q == H_ACT_LAST) && in_box_y) begin
            if (sy_q == S_LAST) begin
                sy_d  = '0;
                row_d = row_q + 3'd1;
            end else begin
                sy_d = sy_q + SW'(1);
            end
        end
    end

    // Word latch, optional blink phase, font lookup and stage-1 next state.
    // At the first pixel the freshly sampled sel is used directly so the
    // whole frame, pixel (0,0) included, shows one consistent word.
    always_comb begin
        word_d = frame_first ? sel : word_q;
`ifdef VPG_WORD_BLINK_EN
        blink_d   = blink_q;
        show_text = (blink_q < BLINK_HALF);
        if (frame_first && (sel != word_q)) begin
            blink_d   = '0;
            show_text = 1'b1;
        end else if ((h_cnt_q == H_LAST) && (v_cnt_q == V_LAST)) begin
            blink_d = (blink_q == BLINK_LAST) ? '0 : blink_q + BLINK_W'(1);
        end
`else
        show_text = 1'b1;
`endif
        glyph = glyph_row(char_code(word_d, chr_q), row_q);
        // Bit index equals dot column; bit 5 is the always-dark spacing column
        row_bits[5] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            row_bits[i] = glyph[4 - i];
        end
        s1_de_d   = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        s1_hs_d   = ((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END)) ? HS_ON : ~HS_ON;
        s1_vs_d   = ((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END)) ? VS_ON : ~VS_ON;
        s1_fs_d   = frame_first;
        s1_txt_d  = in_box_x && in_box_y && show_text;
        s1_col_d  = col_q;
        s1_bits_d = row_bits;
    end

    // Stage 2: choose text/background colour, blank outside active video
    always_comb begin
        de_d  = s1_de_q;
        hs_d  = s1_hs_q;
        vs_d  = s1_vs_q;
        fs_d  = s1_fs_q;
        rgb_d = '0;
        if (s1_de_q) begin
            rgb_d = (s1_txt_q && s1_bits_q[s1_col_q]) ? FG_RGB : BG_RGB;
        end
    end

    // All state registers with synchronous reset to an idle, blanked raster
    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            sx_q      <= '0;
            sy_q      <= '0;
            col_q     <= '0;
            chr_q     <= '0;
            row_q     <= '0;
            word_q    <= '0;
`ifdef VPG_WORD_BLINK_EN
            blink_q   <= '0;
`endif
            s1_de_q   <= 1'b0;
            s1_hs_q   <= ~HS_ON;
            s1_vs_q   <= ~VS_ON;
            s1_fs_q   <= 1'b0;
            s1_txt_q  <= 1'b0;
            s1_col_q  <= '0;
            s1_bits_q <= '0;
            de_q      <= 1'b0;
            hs_q      <= ~HS_ON;
            vs_q      <= ~VS_ON;
            fs_q      <= 1'b0;
            rgb_q     <= '0;
        end else begin
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            sx_q      <= sx_d;
            sy_q      <= sy_d;
            col_q     <= col_d;
            chr_q     <= chr_d;
            row_q     <= row_d;
            word_q    <= word_d;
`ifdef VPG_WORD_BLINK_EN
            blink_q   <= blink_d;
`endif
            s1_de_q   <= s1_de_d;
            s1_hs_q   <= s1_hs_d;
            s1_vs_q   <= s1_vs_d;
            s1_fs_q   <= s1_fs_d;
            s1_txt_q  <= s1_txt_d;
            s1_col_q  <= s1_col_d;
            s1_bits_q <= s1_bits_d;
            de_q      <= de_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            fs_q      <= fs_d;
            rgb_q     <= rgb_d;
        end
    end

    assign vpg_de      = de_q;
    assign vpg_hs      = hs_q;
    assign vpg_vs      = vs_q;
    assign vpg_r       = rgb_q[23:16];
    assign vpg_g       = rgb_q[15:8];
    assign vpg_b       = rgb_q[7:0];
    assign frame_start = fs_q;

endmodule
`default_nettype wire
